maxnet_select_decode: RTL and testbench
=======================================

# maxnet_select_decode

Support block for the 4-neuron Maxnet winner-take-all datapath. It provides the constant 4x4 weight matrix, the init/feedback select for the four activations that feed the processing units, and the winner decoder. The decoder reports when exactly one activation remains nonzero and which one it is. It sits between the activation/X register blocks and the processing units, and its decoder outputs drive the final-result mux select and the controller's completion input.

## Interface
- DW, default 5: activation and weight width, two's complement.
- W_DIAG, default 5'sd8: diagonal (self) weight, +1.0 in Q2.3.
- W_OFF, default -5'sd1: off-diagonal weight, -0.125 in Q2.3. Must satisfy |W_OFF| < W_DIAG/4.

Ports:
- clk  input  1  sole clock; rising edge.
- rst  input  1  reset, synchronous, active-high.
- sel  input  1  1 = select init activations, 0 = select fed-back activations.
- a1_init..a4_init  input  DW each  initial activations (registered X values).
- a1_new..a4_new  input  DW each  activations from the previous iteration.
- a1..a4  output  DW each  selected activations to the PUs; combinational.
- w_flat  output  16*DW  weight matrix, constant.
- idx  output  2  registered winner index.
- complete  output  1  registered; 1 when exactly one a*_new is nonzero.

## Operation
- Select mux, one instance per lane i = 1..4:
  - ai = sel ? ai_init : ai_new.
  - Purely combinational; no X-propagation masking is required.
- Weight buffer:
  - Entry k = 4*r + c (r, c in 0..3) occupies w_flat[DW*k + DW-1 : DW*k].
  - Entry value is W_DIAG when r == c (k = 0, 5, 10, 15) and W_OFF otherwise.
  - Row r feeds PU r+1; column c multiplies activation a(c+1).
  - Constant; unaffected by clk and rst.
- Winner decoder, combinational core on a1_new..a4_new:
  - Lane active when its value != 0 (any nonzero bit pattern).
  - done_c = exactly one lane active.
  - idx_c = index (0..3) of the lowest-numbered active lane; 0 when no lane is active.
  - With multiple active lanes, idx_c still reports the lowest active lane but done_c = 0.
- Output registers:
  - Every rising clk: if rst, then idx <= 0 and complete <= 0; else idx <= idx_c and complete <= done_c.
  - No enable; they track the decoder continuously.

## Timing
- a1..a4 and w_flat: zero-cycle combinational paths; w_flat is static.
- idx and complete: 1-cycle latency from a*_new to the output.
- Reset values: idx = 2'b00, complete = 0. a1..a4 follow their inputs during reset.
- Reset asserted mid-operation clears idx and complete on the next edge, regardless of inputs.
- After reset deasserts, the first edge captures the decoder value.
- sel toggling has no effect on idx or complete; the decoder observes only a*_new.
- Boundary cases:
  - All lanes zero: complete = 0, idx = 0.
  - All four lanes nonzero: complete = 0, idx = 0.
  - Negative values count as active. Upstream ReLU normally prevents them.

## Test plan
- Reset: hold rst=1 for 2 edges with a*_new = {0, 7, 0, 0} -> idx = 0, complete = 0. First edge after release -> idx = 1, complete = 1.
- Mux:
  - sel=1, init = {3, 4, 5, 6}, new = {1, 1, 1, 1} -> a1..a4 = {3, 4, 5, 6}.
  - sel=0 -> a1..a4 = {1, 1, 1, 1}, same cycle.
- Weights: read all 16 entries -> entries 0, 5, 10 and 15 = 5'b01000; the other 12 = 5'b11111.
- Single winner: a*_new = {0, 0, 0, 9} -> next edge idx = 3, complete = 1. Then {2, 0, 0, 0} -> idx = 0, complete = 1.
- Multiple or none:
  - {0, 5, 3, 0} -> complete = 0, idx = 1.
  - {0, 0, 0, 0} -> complete = 0, idx = 0.
  - {1, 1, 1, 1} -> complete = 0, idx = 0.
- Latency check: change a*_new from {0, 0, 4, 0} to {0, 0, 4, 4} between edges. Outputs hold idx = 2, complete = 1 until the next edge, then change to complete = 0, idx = 2.

Source files
------------

// File: rtl/maxnet_select_decode.sv
// Maxnet support block: per-lane init/feedback select, constant 4x4 weight
// matrix, and the single-winner decoder that ends the iteration.
module maxnet_select_decode #(
  parameter int                     DW     = 5,
  parameter logic signed [DW-1:0]   W_DIAG = 5'sd8,
  parameter logic signed [DW-1:0]   W_OFF  = -5'sd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [DW-1:0]    a1_init,
  input  logic [DW-1:0]    a2_init,
  input  logic [DW-1:0]    a3_init,
  input  logic [DW-1:0]    a4_init,
  input  logic [DW-1:0]    a1_new,
  input  logic [DW-1:0]    a2_new,
  input  logic [DW-1:0]    a3_new,
  input  logic [DW-1:0]    a4_new,
  output logic [DW-1:0]    a1,
  output logic [DW-1:0]    a2,
  output logic [DW-1:0]    a3,
  output logic [DW-1:0]    a4,
  output logic [16*DW-1:0] w_flat,
  output logic [1:0]       idx,
  output logic             complete
);

  logic [3:0] act;
  logic [1:0] idx_c;
  logic       done_c;

  assign a1 = sel ? a1_init : a1_new;
  assign a2 = sel ? a2_init : a2_new;
  assign a3 = sel ? a3_init : a3_new;
  assign a4 = sel ? a4_init : a4_new;

  // Row r of the matrix feeds PU r+1; self weight on the diagonal only.
  for (genvar k = 0; k < 16; k++) begin : g_w
    assign w_flat[DW*k +: DW] = ((k / 4) == (k % 4)) ? W_DIAG : W_OFF;
  end

  assign act = {|a4_new, |a3_new, |a2_new, |a1_new};

  always_comb begin
    idx_c = 2'd0;
    // Scan downwards so the lowest-numbered active lane is the last writer.
    for (int i = 3; i >= 0; i--) begin
      if (act[i]) idx_c = 2'(i);
    end
  end

  assign done_c = (act != 4'd0) && ((act & (act - 4'd1)) == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= 2'd0;
      complete <= 1'b0;
    end else begin
      idx      <= idx_c;
      complete <= done_c;
    end
  end

endmodule

// File: tb/tb_maxnet_select_decode.sv
// Self-checking bench for maxnet_select_decode: directed cases plus random
// lanes compared against a count-the-nonzero-lanes reference model.
module tb_maxnet_select_decode;

  localparam int DW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            sel;
  logic [DW-1:0]   iv [4];
  logic [DW-1:0]   nv [4];
  logic [DW-1:0]   a1, a2, a3, a4;
  logic [16*DW-1:0] w_flat;
  logic [1:0]      idx;
  logic            complete;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  maxnet_select_decode #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .sel(sel),
    .a1_init(iv[0]), .a2_init(iv[1]), .a3_init(iv[2]), .a4_init(iv[3]),
    .a1_new(nv[0]), .a2_new(nv[1]), .a3_new(nv[2]), .a4_new(nv[3]),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .w_flat(w_flat), .idx(idx), .complete(complete)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: winner is the first nonzero lane; done only if it is the only one.
  task automatic model(output logic [1:0] e_idx, output logic e_done);
    int count = 0;
    int first = -1;
    for (int i = 0; i < 4; i++) begin
      if (nv[i] != 0) begin
        count++;
        if (first < 0) first = i;
      end
    end
    e_idx  = (first < 0) ? 2'd0 : 2'(first);
    e_done = (count == 1);
  endtask

  task automatic set_new(input int v0, input int v1, input int v2, input int v3);
    nv[0] = DW'(v0); nv[1] = DW'(v1); nv[2] = DW'(v2); nv[3] = DW'(v3);
  endtask

  task automatic clock_and_check(input string tag, input logic [1:0] e_idx, input logic e_done);
    @(posedge clk);
    #1;
    check({tag, "_idx"}, 32'(idx), 32'(e_idx));
    check({tag, "_complete"}, 32'(complete), 32'(e_done));
  endtask

  task automatic check_mux(input string tag);
    logic [DW-1:0] exp_a [4];
    for (int i = 0; i < 4; i++) exp_a[i] = sel ? iv[i] : nv[i];
    check({tag, "_a1"}, 32'(a1), 32'(exp_a[0]));
    check({tag, "_a2"}, 32'(a2), 32'(exp_a[1]));
    check({tag, "_a3"}, 32'(a3), 32'(exp_a[2]));
    check({tag, "_a4"}, 32'(a4), 32'(exp_a[3]));
  endtask

  initial begin
    logic [1:0] e_idx;
    logic       e_done;
    logic [DW-1:0] w_exp;

    rst = 1'b1;
    sel = 1'b0;
    for (int i = 0; i < 4; i++) iv[i] = '0;
    set_new(0, 7, 0, 0);
    #1;

    clock_and_check("rst_edge1", 2'd0, 1'b0);
    clock_and_check("rst_edge2", 2'd0, 1'b0);
    rst = 1'b0;
    clock_and_check("rst_release", 2'd1, 1'b1);

    // Mux, both selections within the same cycle.
    iv[0] = 5'd3; iv[1] = 5'd4; iv[2] = 5'd5; iv[3] = 5'd6;
    set_new(1, 1, 1, 1);
    sel = 1'b1;
    #1;
    check_mux("mux_init");
    check("mux_init_a1_lit", 32'(a1), 32'd3);
    check("mux_init_a4_lit", 32'(a4), 32'd6);
    sel = 1'b0;
    #1;
    check_mux("mux_new");
    check("mux_new_a3_lit", 32'(a3), 32'd1);

    // Weights.
    for (int k = 0; k < 16; k++) begin
      w_exp = ((k / 4) == (k % 4)) ? 5'b01000 : 5'b11111;
      check($sformatf("w%0d", k), 32'(w_flat[DW*k +: DW]), 32'(w_exp));
    end

    set_new(0, 0, 0, 9);  clock_and_check("single_l4", 2'd3, 1'b1);
    set_new(2, 0, 0, 0);  clock_and_check("single_l1", 2'd0, 1'b1);
    set_new(0, 5, 3, 0);  clock_and_check("multi_23", 2'd1, 1'b0);
    set_new(0, 0, 0, 0);  clock_and_check("none", 2'd0, 1'b0);
    set_new(1, 1, 1, 1);  clock_and_check("all", 2'd0, 1'b0);
    set_new(0, 0, 0, 31); clock_and_check("neg_l4", 2'd3, 1'b1);

    // Latency: outputs hold until the edge after the input change.
    set_new(0, 0, 4, 0);  clock_and_check("lat_a", 2'd2, 1'b1);
    set_new(0, 0, 4, 4);
    #2;
    check("lat_hold_idx", 32'(idx), 32'd2);
    check("lat_hold_complete", 32'(complete), 32'd1);
    clock_and_check("lat_b", 2'd2, 1'b0);

    // Mid-operation reset overrides the decoder.
    set_new(0, 6, 0, 0);
    rst = 1'b1;
    clock_and_check("rst_mid", 2'd0, 1'b0);
    rst = 1'b0;
    clock_and_check("rst_mid_release", 2'd1, 1'b1);

    // Random: lanes are zero half the time so single winners are common.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) begin
        iv[i] = DW'($urandom);
        nv[i] = ($urandom_range(1, 0) == 0) ? '0 : DW'($urandom_range(31, 1));
      end
      sel = 1'($urandom);
      rst = ($urandom_range(15, 0) == 0);
      #1;
      check_mux("rnd_mux");
      model(e_idx, e_done);
      if (rst) begin
        e_idx  = 2'd0;
        e_done = 1'b0;
      end
      clock_and_check("rnd", e_idx, e_done);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
